// File: rtl/params_pkg.sv
// Shared fetch-path types and widths: instruction word, fetch FSM states, skid entry payload.
package params_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = ADDR_WIDTH'(32'h0000_1000);

    typedef logic [DATA_WIDTH-1:0] instruction_t;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        instruction_t          instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instruction} holding buffer used while decode stalls; flush wins over load/unload.
module fetch_skid_buf
    import params_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load,
    input  logic         unload,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t rd_entry,
    output logic         full
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full     <= 1'b0;
            rd_entry <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            rd_entry <= wr_entry;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, single-outstanding imem reads, stall skid and redirect squash.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import params_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  is_jump_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] target_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
`ifdef FETCH_PERF_EN
    output logic [31:0]           perf_fetched_o,
    output logic [31:0]           perf_stall_o,
`endif
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output instruction_t          instruction_o
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_d;
    logic [ADDR_WIDTH-1:0] pc_out_d;
    instruction_t          instr_out_d;

    logic redirect, consume, out_free, drain_needed;
    logic skid_load, skid_unload, skid_flush, skid_full;
    fetch_entry_t skid_wr, skid_rd;

    assign redirect    = is_jump_i | branch_taken_i;
    assign consume     = valid_o & ~stall_i;
    assign out_free    = ~valid_o | ~stall_i;
    assign imem_req_o  = (state_q == S_REQ) & ~rst_i;
    assign imem_addr_o = pc_q;
    assign skid_wr     = '{pc: pc_q, instr: imem_rsp_data_i};

    // A request stays in flight past a redirect unless its response lands in the same cycle.
    assign drain_needed = ((state_q == S_REQ) & imem_gnt_i)
                        | (((state_q == S_WAIT) | (state_q == S_DRAIN)) & ~imem_rsp_valid_i);

    fetch_skid_buf u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (skid_flush),
        .wr_entry (skid_wr),
        .rd_entry (skid_rd),
        .full     (skid_full)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_o & ~consume;
        pc_out_d    = pc_o;
        instr_out_d = instruction_o;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        if (redirect) begin
            pc_d       = target_pc_i & ALIGN_MASK;
            valid_d    = 1'b0;
            skid_flush = 1'b1;
            state_d    = drain_needed ? S_DRAIN : S_REQ;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_gnt_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        pc_d = pc_q + PC_STEP;
                        if (out_free) begin
                            valid_d     = 1'b1;
                            pc_out_d    = pc_q;
                            instr_out_d = imem_rsp_data_i;
                            state_d     = S_REQ;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_free) begin
                        valid_d     = skid_full;
                        pc_out_d    = skid_rd.pc;
                        instr_out_d = skid_rd.instr;
                        skid_unload = 1'b1;
                        state_d     = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            valid_o       <= 1'b0;
            pc_o          <= '0;
            instruction_o <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            valid_o       <= valid_d;
            pc_o          <= pc_out_d;
            instruction_o <= instr_out_d;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters: delivered instructions and stalled-valid cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (consume && (perf_fetched_o != '1))
                perf_fetched_o <= perf_fetched_o + 32'd1;
            if (valid_o && stall_i && (perf_stall_o != '1))
                perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
